// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back cache.
package cache_pkg;

    localparam int DEF_DATA_W          = 8;
    localparam int DEF_ADDR_W          = 8;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_NUM_LINES       = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    function automatic int offset_w(input int wpb);
        return $clog2(wpb);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int aw, input int wpb, input int lines);
        return aw - $clog2(wpb) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Line storage: valid/dirty/tag/data with async indexed read,
// synchronous word write and block fill.
module dm_cache_array
    import cache_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_LINES       = DEF_NUM_LINES,
    parameter int TAG_W           = 3,
    localparam int OFFSET_W       = offset_w(WORDS_PER_BLOCK),
    localparam int INDEX_W        = index_w(NUM_LINES),
    localparam int BLOCK_W        = DATA_W * WORDS_PER_BLOCK
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [INDEX_W-1:0]  idx_i,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [BLOCK_W-1:0]  data_o,
    input  logic                word_we_i,
    input  logic [OFFSET_W-1:0] word_off_i,
    input  logic [DATA_W-1:0]   word_i,
    input  logic                fill_en_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [BLOCK_W-1:0]  fill_data_i,
    input  logic                clr_dirty_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    // Tag and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_off_i*DATA_W +: DATA_W] <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back write-allocate cache: miss FSM,
// hit logic, word select/merge and memory port drive.
module dm_wb_cache
    import cache_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_LINES       = DEF_NUM_LINES,
    localparam int OFFSET_W       = offset_w(WORDS_PER_BLOCK),
    localparam int INDEX_W        = index_w(NUM_LINES),
    localparam int TAG_W          = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_LINES),
    localparam int BLOCK_W        = DATA_W * WORDS_PER_BLOCK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          write_data,
    output logic [DATA_W-1:0]          read_data,
    output logic                       busy_wait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]         mem_write_data,
    input  logic [BLOCK_W-1:0]         mem_read_data,
    input  logic                       mem_busy_wait
);

    state_e state_q, state_d;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_idx;
    logic [OFFSET_W-1:0] addr_off;

    assign addr_tag = address[ADDR_W-1 -: TAG_W];
    assign addr_idx = address[OFFSET_W +: INDEX_W];
    assign addr_off = address[OFFSET_W-1:0];

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               word_we;
    logic               fill_en;
    logic               clr_dirty;
    logic               busy_c;
    logic [DATA_W-1:0]  rdata_c;

    assign hit = line_valid && (line_tag == addr_tag);

    dm_cache_array #(
        .DATA_W          (DATA_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .NUM_LINES       (NUM_LINES),
        .TAG_W           (TAG_W)
    ) u_array (
        .clk_i       (clk),
        .rst_ni      (rst),
        .idx_i       (addr_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .word_we_i   (word_we),
        .word_off_i  (addr_off),
        .word_i      (write_data),
        .fill_en_i   (fill_en),
        .fill_tag_i  (addr_tag),
        .fill_data_i (mem_read_data),
        .clr_dirty_i (clr_dirty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_c      = 1'b0;
        rdata_c     = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = {addr_tag, addr_idx};
        word_we     = 1'b0;
        fill_en     = 1'b0;
        clr_dirty   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read ^ write) begin
                    if (hit) begin
                        rdata_c = read ? line_data[addr_off*DATA_W +: DATA_W] : '0;
                        word_we = write;
                    end else begin
                        busy_c  = 1'b1;
                        state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {line_tag, addr_idx};
                busy_c      = 1'b1;
                if (!mem_busy_wait) begin
                    clr_dirty = 1'b1;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                busy_c   = 1'b1;
                if (!mem_busy_wait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held reset masks the combinational miss/hit paths too.
    assign busy_wait      = rst & busy_c;
    assign read_data      = rst ? rdata_c : '0;
    assign mem_write_data = line_data;

endmodule

// File: tb/tb_dm_wb_cache.sv
// Self-checking bench for dm_wb_cache with a 5-cycle-busy block memory.
module tb_dm_wb_cache;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        busy_wait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_busy_wait;

    dm_wb_cache dut (
        .clk            (clk),
        .rst            (rst),
        .read           (read),
        .write          (write),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .busy_wait      (busy_wait),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_busy_wait  (mem_busy_wait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } mev_t;

    mev_t wb_q[$];
    mev_t fill_q[$];
    logic [7:0] exp_q[$];

    logic [31:0] mem [64];
    int unsigned cnt;
    logic        req;

    assign req           = mem_read | mem_write;
    assign mem_busy_wait = req && (cnt < 5);
    assign mem_read_data = mem[mem_address];

    always @(posedge clk) begin
        if (req && cnt >= 5) begin
            cnt <= 0;
            if (mem_write) begin
                mem[mem_address] <= mem_write_data;
                wb_q.push_back('{a: mem_address, d: mem_write_data});
            end else begin
                fill_q.push_back('{a: mem_address, d: mem[mem_address]});
            end
        end else if (req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL mem_excl: mem_read=1 mem_write=1 required not both");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  rdat;
        logic        stall;
        logic [1:0]  n_wb;
        logic [5:0]  wb_a;
        logic [31:0] wb_d;
        logic [1:0]  n_fill;
        logic [5:0]  fill_a;
    } vec_t;

    vec_t vec [12];

    task automatic wait_idle(input string nm);
        int cyc = 0;
        while (busy_wait && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (busy_wait) begin
            errors++;
            $display("FAIL %s_timeout: busy_wait=1 after %0d cycles", nm, cyc);
        end
    endtask

    task automatic access(input vec_t v, input int n);
        string nm;
        logic [7:0] e;
        nm = $sformatf("v%0d", n);
        @(negedge clk);
        wb_q.delete();
        fill_q.delete();
        read       = v.rd;
        write      = v.wr;
        address    = v.addr;
        write_data = v.wd;
        exp_q.push_back(v.rdat);
        #1;
        chk({nm, "_stall"}, 32'(busy_wait), 32'(v.stall));
        wait_idle(nm);
        e = exp_q.pop_front();
        chk({nm, "_rdata"}, 32'(read_data), 32'(e));
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk({nm, "_wb_cnt"}, 32'(wb_q.size()), 32'(v.n_wb));
        if (v.n_wb != 0 && wb_q.size() != 0) begin
            chk({nm, "_wb_addr"}, 32'(wb_q[0].a), 32'(v.wb_a));
            chk({nm, "_wb_data"}, wb_q[0].d, v.wb_d);
        end
        chk({nm, "_fill_cnt"}, 32'(fill_q.size()), 32'(v.n_fill));
        if (v.n_fill != 0 && fill_q.size() != 0) begin
            chk({nm, "_fill_addr"}, 32'(fill_q[0].a), 32'(v.fill_a));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
        end
        mem[7]  = 32'h44332211;
        mem[15] = 32'h88776655;
        mem[16] = 32'hDDCCBBAA;

        vec[0]  = '{1'b1, 1'b0, 8'h1E, 8'h00, 8'h33, 1'b1,
                    2'd0, 6'h00, 32'h0, 2'd1, 6'h07};
        vec[1]  = '{1'b1, 1'b0, 8'h1C, 8'h00, 8'h11, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[2]  = '{1'b0, 1'b1, 8'h1D, 8'hAB, 8'h00, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[3]  = '{1'b1, 1'b0, 8'h1D, 8'h00, 8'hAB, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[4]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'h55, 1'b1,
                    2'd1, 6'h07, 32'h4433AB11, 2'd1, 6'h0F};
        vec[5]  = '{1'b0, 1'b1, 8'h40, 8'h55, 8'h00, 1'b1,
                    2'd0, 6'h00, 32'h0, 2'd1, 6'h10};
        vec[6]  = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h55, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[7]  = '{1'b1, 1'b0, 8'h1E, 8'h00, 8'h33, 1'b1,
                    2'd0, 6'h00, 32'h0, 2'd1, 6'h07};
        vec[8]  = '{1'b1, 1'b0, 8'h1D, 8'h00, 8'hAB, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[9]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h20, 1'b1,
                    2'd1, 6'h10, 32'hDDCCBB55, 2'd1, 6'h20};
        vec[10] = '{1'b1, 1'b1, 8'h1C, 8'h77, 8'h00, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};
        vec[11] = '{1'b0, 1'b0, 8'h99, 8'h00, 8'h00, 1'b0,
                    2'd0, 6'h00, 32'h0, 2'd0, 6'h00};

        rst        = 1'b0;
        read       = 1'b1;
        write      = 1'b0;
        address    = 8'h1E;
        write_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy_wait), 32'd0);
        chk("rst_rdata", 32'(read_data), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            access(vec[i], i);
        end

        // Reset in the middle of ALLOCATE, then refetch.
        @(negedge clk);
        read    = 1'b1;
        address = 8'h44;
        begin
            int cyc = 0;
            while (!mem_read && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("abort_mem_read_seen", 32'(mem_read), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_busy", 32'(busy_wait), 32'd0);
        @(negedge clk);
        fill_q.delete();
        wb_q.delete();
        rst = 1'b1;
        exp_q.push_back(8'h11);
        #1;
        chk("refetch_stall", 32'(busy_wait), 32'd1);
        wait_idle("refetch");
        chk("refetch_rdata", 32'(read_data), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        read = 1'b0;
        chk("refetch_fill_cnt", 32'(fill_q.size()), 32'd1);
        chk("refetch_wb_cnt", 32'(wb_q.size()), 32'd0);
        if (fill_q.size() != 0) begin
            chk("refetch_fill_addr", 32'(fill_q[0].a), 32'h11);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
